// File: rtl/control_contador_if.sv
// Pushbutton/counter-side signals of control_contador, grouped for port use.
interface control_contador_if;
  logic iBTN_RUN;
  logic iBTN_DIR;
  logic iTC;
  logic oENABLE;
  logic oUP_DOWN;
  logic oRUN;

  modport master (output iBTN_RUN, iBTN_DIR, iTC, input oENABLE, oUP_DOWN, oRUN);
  modport slave  (input iBTN_RUN, iBTN_DIR, iTC, output oENABLE, oUP_DOWN, oRUN);
endinterface

// File: rtl/control_contador.sv
// Run/stop + direction control for the up/down counter: debounced keys, prescaled enable.
// Optional auto-stop on terminal count when STOP_AT_TC_EN is defined.
module control_contador_btn #(
  parameter int DEBOUNCE_CYCLES = 1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_i,
  output logic press_o
);
  localparam int             CW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic [1:0]    sync_q;
  logic          level_q, level_d, prev_q;
  logic [CW-1:0] cnt_q, cnt_d;

  // counter only survives while sync keeps disagreeing with the accepted level
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    if (sync_q[1] != level_q) begin
      if (cnt_q == LAST) level_d = sync_q[1];
      else               cnt_d   = cnt_q + ONE;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q  <= 2'b11;
      level_q <= 1'b1;
      prev_q  <= 1'b1;
      cnt_q   <= '0;
    end else begin
      sync_q  <= {sync_q[0], btn_i};
      level_q <= level_d;
      prev_q  <= level_q;
      cnt_q   <= cnt_d;
    end
  end

  assign press_o = prev_q & ~level_q;
endmodule

module control_contador #(
  parameter int PRESCALER       = 50_000_000,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic                iCLOCK,
  input  logic                iRESET,
  control_contador_if.slave   bus
);
  localparam int NUM_LANES = 2;
  localparam int L_RUN = 0;
  localparam int L_DIR = 1;
  localparam int             PW     = (PRESCALER > 1) ? $clog2(PRESCALER) : 1;
  localparam logic [PW-1:0] P_LAST = PW'(PRESCALER - 1);
  localparam logic [PW-1:0] P_ONE  = PW'(1);

  typedef enum logic {ST_STOP, ST_RUN} state_t;

  logic [NUM_LANES-1:0] btn_raw, press;
  state_t               state_q, state_d;
  logic [PW-1:0]        presc_q, presc_d;
  logic                 en_q, en_d, up_q, up_d;
  logic                 wrap, tc_stop;

  assign btn_raw = {bus.iBTN_DIR, bus.iBTN_RUN};

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_btn
    control_contador_btn #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn (
      .clk_i  (iCLOCK),
      .rst_i  (iRESET),
      .btn_i  (btn_raw[g]),
      .press_o(press[g])
    );
  end

  assign wrap = (presc_q == P_LAST);

`ifdef STOP_AT_TC_EN
  assign tc_stop = wrap & bus.iTC;
`else
  logic unused_tc;
  assign unused_tc = bus.iTC;
  assign tc_stop   = 1'b0;
`endif

  // any exit from RUN clears the prescaler and swallows a pulse due that cycle
  always_comb begin
    state_d = state_q;
    presc_d = '0;
    en_d    = 1'b0;
    up_d    = up_q ^ press[L_DIR];
    case (state_q)
      ST_STOP: if (press[L_RUN]) state_d = ST_RUN;
      ST_RUN: begin
        if (press[L_RUN] || tc_stop) begin
          state_d = ST_STOP;
        end else begin
          presc_d = wrap ? '0 : presc_q + P_ONE;
          en_d    = wrap;
        end
      end
      default: state_d = ST_STOP;
    endcase
  end

  always_ff @(posedge iCLOCK or posedge iRESET) begin
    if (iRESET) begin
      state_q <= ST_STOP;
      presc_q <= '0;
      en_q    <= 1'b0;
      up_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      en_q    <= en_d;
      up_q    <= up_d;
    end
  end

  assign bus.oENABLE  = en_q;
  assign bus.oUP_DOWN = up_q;
  assign bus.oRUN     = (state_q == ST_RUN);
endmodule

// File: tb/tb_control_contador.sv
// Randomised + directed bench for control_contador against a behavioural model.
module tb_control_contador;
  localparam int P   = 4;
  localparam int DEB = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  control_contador_if bus();

  control_contador #(.PRESCALER(P), .DEBOUNCE_CYCLES(DEB)) dut (
    .iCLOCK(clk), .iRESET(rst), .bus(bus)
  );

  always #10 clk = ~clk;

  // ---------------- behavioural model ----------------
  bit m_run = 0, m_up = 1, m_en = 0;
  int m_since = 0;
  bit lvl_r = 1, lvl_d = 1, pend_r = 0, pend_d = 0;
  bit q_r[$], q_d[$];

`ifdef STOP_AT_TC_EN
  localparam bit TC_FEAT = 1'b1;
`else
  localparam bit TC_FEAT = 1'b0;
`endif

  // level flips once the last DEB synchronised samples (raw delayed 2 edges) all disagree
  function automatic bit settled(input bit qq[$], input bit l);
    int sz;
    sz = qq.size();
    for (int i = 0; i < DEB; i++) begin
      int idx;
      bit v;
      idx = sz - 3 - i;
      v   = (idx >= 0) ? qq[idx] : 1'b1;
      if (v == l) return 1'b0;
    end
    return 1'b1;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_run = 0; m_up = 1; m_en = 0; m_since = 0;
      lvl_r = 1; lvl_d = 1; pend_r = 0; pend_d = 0;
      q_r = '{1'b1, 1'b1};
      q_d = '{1'b1, 1'b1};
    end else begin
      m_en = 0;
      if (pend_r) begin
        m_run = !m_run;
        m_since = 0;
      end else if (m_run) begin
        m_since++;
        if (m_since % P == 0) begin
          if (TC_FEAT && bus.iTC) begin m_run = 0; m_since = 0; end
          else m_en = 1;
        end
      end
      if (pend_d) m_up = !m_up;
      q_r.push_back(bus.iBTN_RUN);
      q_d.push_back(bus.iBTN_DIR);
      if (q_r.size() > 32) void'(q_r.pop_front());
      if (q_d.size() > 32) void'(q_d.pop_front());
      pend_r = 0;
      pend_d = 0;
      if (settled(q_r, lvl_r)) begin pend_r = lvl_r; lvl_r = !lvl_r; end
      if (settled(q_d, lvl_d)) begin pend_d = lvl_d; lvl_d = !lvl_d; end
    end
  end

  task automatic chk(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0b exp=%0b t=%0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("enable", bus.oENABLE, m_en);
    chk("up_down", bus.oUP_DOWN, m_up);
    chk("run", bus.oRUN, m_run);
  end

  // ---------------- stimulus ----------------
  task automatic press_btn(input bit dir, input int n);
    @(posedge clk); #2;
    if (dir) bus.iBTN_DIR = 0; else bus.iBTN_RUN = 0;
    repeat (n) @(posedge clk);
    #2;
    if (dir) bus.iBTN_DIR = 1; else bus.iBTN_RUN = 1;
    repeat (8) @(posedge clk);
  endtask

  task automatic reset_pins(input string tag);
    chk({tag, "_en"}, bus.oENABLE, 1'b0);
    chk({tag, "_run"}, bus.oRUN, 1'b0);
    chk({tag, "_up"}, bus.oUP_DOWN, 1'b1);
  endtask

  initial begin
    int hr, hd;
    bus.iBTN_RUN = 1; bus.iBTN_DIR = 1; bus.iTC = 0;
    repeat (3) @(posedge clk);
    #2 rst = 0;
    #1 reset_pins("rst_init");
    repeat (4) @(posedge clk);

    // run start: press from just after edge 0
    @(posedge clk);
    for (int k = 1; k <= 16; k++) begin
      if (k == 1) begin #2 bus.iBTN_RUN = 0; @(posedge clk); end
      else @(posedge clk);
      #2;
      if (k == 10) bus.iBTN_RUN = 1;
      #3;
      case (k)
        5:  chk("run_e5", bus.oRUN, 1'b0);
        6:  chk("run_e6", bus.oRUN, 1'b1);
        9:  chk("en_e9", bus.oENABLE, 1'b0);
        10: chk("en_e10", bus.oENABLE, 1'b1);
        11: chk("en_e11", bus.oENABLE, 1'b0);
        14: chk("en_e14", bus.oENABLE, 1'b1);
        default: ;
      endcase
    end

    // bounce: 2-cycle glitch must not toggle
    @(posedge clk); #2 bus.iBTN_RUN = 0;
    repeat (2) @(posedge clk);
    #2 bus.iBTN_RUN = 1;
    repeat (10) @(posedge clk);
    #5 chk("bounce_run", bus.oRUN, 1'b1);

    // direction while running
    @(posedge clk);
    for (int k = 1; k <= 10; k++) begin
      if (k == 1) begin #2 bus.iBTN_DIR = 0; @(posedge clk); end
      else @(posedge clk);
      #2;
      if (k == 6) bus.iBTN_DIR = 1;
      #3;
      if (k == 5) chk("dir_e5", bus.oUP_DOWN, 1'b1);
      if (k == 6) chk("dir_e6", bus.oUP_DOWN, 1'b0);
    end
    press_btn(1, 5);
    press_btn(1, 5);

    // async reset mid-run, between edges
    @(posedge clk); #2 rst = 1;
    #1 reset_pins("rst_mid");
    repeat (3) @(posedge clk);
    #2 rst = 0;
    repeat (10) @(posedge clk);

    // stop / restart, then terminal-count handling
    press_btn(0, 6);
    repeat (12) @(posedge clk);
    press_btn(0, 6);
    repeat (10) @(posedge clk);
    #5 chk("stopped", bus.oRUN, 1'b0);
    @(posedge clk);
    for (int k = 1; k <= 20; k++) begin
      if (k == 1) begin #2 bus.iBTN_RUN = 0; @(posedge clk); end
      else @(posedge clk);
      #2;
      if (k == 6) bus.iBTN_RUN = 1;
      if (k == 15) bus.iTC = 1;
      if (k == 19) bus.iTC = 0;
      #3;
      case (k)
        6:  chk("rs_run_e6", bus.oRUN, 1'b1);
        10: chk("rs_en_e10", bus.oENABLE, 1'b1);
        13: chk("rs_en_e13", bus.oENABLE, 1'b0);
        14: chk("rs_en_e14", bus.oENABLE, 1'b1);
        18: begin
          chk("tc_en_e18", bus.oENABLE, !TC_FEAT);
          chk("tc_run_e18", bus.oRUN, !TC_FEAT);
        end
        default: ;
      endcase
    end

    // randomised phase
    hr = 0; hd = 0;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #2;
      if (hr == 0) begin bus.iBTN_RUN = 1'($urandom_range(0, 1)); hr = $urandom_range(1, 8); end
      else hr--;
      if (hd == 0) begin bus.iBTN_DIR = 1'($urandom_range(0, 1)); hd = $urandom_range(1, 8); end
      else hd--;
      bus.iTC = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 599) == 0) begin
        rst = 1;
        #1 reset_pins("rst_rand");
        repeat (2) @(posedge clk);
        #2 rst = 0;
      end
    end

    bus.iBTN_RUN = 1; bus.iBTN_DIR = 1; bus.iTC = 0;
    repeat (10) @(posedge clk);
    #5;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
